product_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit multiplier. It takes the 16-bit product {Aval, Bval} and converts it to a sign flag plus five BCD digits for decimal display, using one double-dabble iteration per clock. A Start/Busy/Done handshake frames each conversion, and the last result is held on the outputs until the next one completes.

---
 rtl/product_bcd_pkg.sv | 15 +
 rtl/product_bcd_converter_if.sv | 40 ++++
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/product_bcd_converter.sv | 119 +++++++++++
 tb/tb_product_bcd_converter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the product-to-BCD converter.
// Build option: define SIGNED_PRODUCT_EN to treat the product as two's complement.
package product_bcd_pkg;

  localparam int PRODUCT_WIDTH = 16;
  localparam int BCD_DIGITS    = 5;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Handshake/data bundle between the multiplier side and the BCD converter.
//
// Handshake: the master raises Start with Product valid. The converter accepts
// on the first rising edge where Start is high while it is idle. Product is only
// sampled on that edge. Busy is high from acceptance until the completion edge.
// Done pulses for one cycle with Bcd/Neg updated on that same edge. Start seen
// while Busy is ignored and never queued. Bcd/Neg hold until the next completion.
interface product_bcd_converter_if
  import product_bcd_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
);

  logic                  Start;
  logic [WIDTH-1:0]      Product;
  logic                  Busy;
  logic                  Done;
  logic                  Neg;
  logic [4*DIGITS-1:0]   Bcd;

  modport master (
    output Start,
    output Product,
    input  Busy,
    input  Done,
    input  Neg,
    input  Bcd
  );

  modport slave (
    input  Start,
    input  Product,
    output Busy,
    output Done,
    output Neg,
    output Bcd
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import product_bcd_pkg::*;
(
  input  digit_t din,
  output digit_t dout
);

  // 4-bit add, any carry out is intentionally dropped (digits never exceed 9)
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
// Build option: SIGNED_PRODUCT_EN selects two's-complement Product with a sign flag;
// without it Product is unsigned and Neg stays 0.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
)(
  input  logic                     Clk,
  input  logic                     Reset,
  product_bcd_converter_if.slave   bus,
  output state_t                   dbg_state
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam int              BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   shift_r;
  logic [BCD_W-1:0]   scratch_r;
  logic               neg_r;
  logic               busy_r;
  logic               done_r;
  logic               neg_out_r;
  logic [BCD_W-1:0]   bcd_r;

  logic [BCD_W-1:0]        adj;
  logic [BCD_W+WIDTH-1:0]  chain;
  logic [BCD_W+WIDTH-1:0]  chain_sh;
  logic                    start_neg;
  logic [WIDTH-1:0]        start_mag;

  // Per-digit "+3 if >= 5" correction on the scratch register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch_r[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Adjusted scratch and shift register move left together as one word;
  // the bit pushed out of the top is discarded by the shift itself
  always_comb begin
    chain    = {adj, shift_r};
    chain_sh = chain << 1;
  end

`ifdef SIGNED_PRODUCT_EN
  // Two's-complement input: negate negatives. 0x8000 negates to 0x8000, which
  // read as unsigned is 32768, so the dropped 17th bit is always zero.
  always_comb begin
    start_neg = bus.Product[WIDTH-1];
    start_mag = bus.Product;
    if (start_neg) begin
      start_mag = ~bus.Product + WIDTH'(1);
    end
  end
`else
  // Unsigned input: the product is already the magnitude
  always_comb begin
    start_neg = 1'b0;
    start_mag = bus.Product;
  end
`endif

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      shift_r   <= '0;
      scratch_r <= '0;
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      neg_out_r <= 1'b0;
      bcd_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.Start) begin
            shift_r   <= start_mag;
            neg_r     <= start_neg;
            scratch_r <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b1;
            state_r   <= CONV;
          end
        end
        CONV: begin
          scratch_r <= chain_sh[BCD_W+WIDTH-1:WIDTH];
          shift_r   <= chain_sh[WIDTH-1:0];
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST) begin
            bcd_r     <= chain_sh[BCD_W+WIDTH-1:WIDTH];
            neg_out_r <= neg_r;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy  = busy_r;
  assign bus.Done  = done_r;
  assign bus.Neg   = neg_out_r;
  assign bus.Bcd   = bcd_r;
  assign dbg_state = state_r;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed plus randomized bench for product_bcd_converter.
// The expected decimal digits come from plain integer arithmetic on the product.
module tb_product_bcd_converter;
  import product_bcd_pkg::*;

  logic   Clk;
  logic   Reset;
  state_t dbg_state;

  product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: {neg, bcd} of accepted conversions, oldest first
  logic [20:0] exp_q[$];
  logic [20:0] last_result = '0;

  // Reference: sign/magnitude from the build mode, digits from repeated /10
  function automatic logic [20:0] model(input logic [15:0] p);
    int unsigned mag;
    logic        neg;
    logic [19:0] digits;
    mag = p;
    neg = 1'b0;
`ifdef SIGNED_PRODUCT_EN
    if (p[15]) begin
      neg = 1'b1;
      mag = 65536 - int'(p);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      digits[i*4 +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {neg, digits};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present Product with Start at a falling edge; returns after the accepting edge
  task automatic start_conv(input logic [15:0] p);
    @(negedge Clk);
    bus.Start   = 1'b1;
    bus.Product = p;
    exp_q.push_back(model(p));
    @(posedge Clk);
    #1;
    bus.Start   = 1'b0;
    bus.Product = 16'($urandom);
    check("busy_after_accept", 32'(bus.Busy), 32'd1);
  endtask

  // Wait for Done; cyc0 edges since acceptance have already passed
  task automatic wait_done(input string tag, input int cyc0);
    int          cyc;
    bit          got;
    logic [20:0] e;
    cyc = cyc0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (bus.Done) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd16);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    if (got) begin
      check({tag, "_bcd"}, 32'(bus.Bcd), 32'(e[19:0]));
      check({tag, "_neg"}, 32'(bus.Neg), 32'(e[20]));
      check({tag, "_busy_low"}, 32'(bus.Busy), 32'd0);
      last_result = e;
    end
    @(posedge Clk);
    #1;
    check({tag, "_done_single"}, 32'(bus.Done), 32'd0);
  endtask

  // Count Done pulses over n cycles
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) pulses++;
    end
  endtask

  int pulses;
  int done_cyc[3];
  int ndone;
  int cyc;

  initial begin
    bus.Start   = 1'b0;
    bus.Product = '0;
    Reset       = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_neg",  32'(bus.Neg),  32'd0);
    check("rst_bcd",  32'(bus.Bcd),  32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge Clk);
    Reset = 1'b0;

    // Directed corner values
    start_conv(16'h0000); wait_done("zero", 0);
    start_conv(16'hFFEB); wait_done("ffeb", 0);
    start_conv(16'h7FFF); wait_done("7fff", 0);
    start_conv(16'h8000); wait_done("8000", 0);
    start_conv(16'hFFFF); wait_done("ffff", 0);

    // Results hold between conversions
    repeat (5) @(posedge Clk);
    #1;
    check("hold_bcd", 32'(bus.Bcd), 32'(last_result[19:0]));
    check("hold_neg", 32'(bus.Neg), 32'(last_result[20]));

    // Randomized conversions
    for (int i = 0; i < 8; i++) begin
      start_conv(16'($urandom_range(0, 65535)));
      wait_done("rand", 0);
    end

    // Start during conversion is ignored, not queued
    start_conv(16'd1234);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    bus.Start   = 1'b1;
    bus.Product = 16'd4321;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    wait_done("ignore_start", 5);
    count_done(20, pulses);
    check("ignore_no_extra_done", 32'(pulses), 32'd0);

    // Asynchronous reset mid-conversion aborts without Done
    start_conv(16'd9999);
    repeat (7) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_neg",  32'(bus.Neg),  32'd0);
    check("abort_bcd",  32'(bus.Bcd),  32'd0);
    exp_q.delete();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    count_done(25, pulses);
    check("abort_no_done", 32'(pulses), 32'd0);
    start_conv(16'd31415); wait_done("after_abort", 0);

    // Start held high: one conversion every 17 clocks
    @(negedge Clk);
    bus.Start   = 1'b1;
    bus.Product = 16'h0064;
    @(posedge Clk);
    #1;
    cyc   = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 80) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (bus.Done) begin
        done_cyc[ndone] = cyc;
        check("b2b_bcd", 32'(bus.Bcd), 32'(model(16'h0064)));
        ndone++;
      end
    end
    bus.Start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      check("b2b_first", 32'(done_cyc[0]), 32'd16);
      check("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd17);
      check("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd17);
    end
    count_done(20, pulses);
    check("b2b_stop", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
